// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with store buffer, load forwarding and 1-cycle loads
module dmem_responder #(
  parameter int ADDR_W   = 8,
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic [31:0] read_address,
  input  logic [2:0]  read_funct3,
  input  logic        write_enabled,
  input  logic [31:0] write_address,
  input  logic [31:0] data_write,
  input  logic [1:0]  write_funct3,
  output logic        stall,
  output logic [31:0] data_out,
  output logic        rd_valid,
  output logic [1:0]  misaligned
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int WORDS = 1 << ADDR_W;

  // Single-port word array; contents survive reset.
  logic [31:0] mem [WORDS];

  // Store buffer: word index, byte mask and lane-aligned data per entry.
  logic [ADDR_W-1:0] sb_idx  [SB_DEPTH];
  logic [3:0]        sb_mask [SB_DEPTH];
  logic [31:0]       sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;

  logic              sb_empty;
  logic              sb_full;

  // Load decode.
  logic [1:0]        ld_off;
  logic [ADDR_W-1:0] ld_idx;
  logic              ld_legal;

  // Store decode.
  logic [1:0]        st_off;
  logic [ADDR_W-1:0] st_idx;
  logic              st_legal;
  logic [3:0]        st_mask;
  logic [31:0]       st_wdata;

  // Port arbitration.
  logic              st_acc;
  logic              enq;
  logic              drain;
  logic              direct;

  // Array write port.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;

  // Load result path.
  logic [31:0]       fwd_word;
  logic [31:0]       sel_word;
  logic [31:0]       ld_result;

  // Address bits above the array wrap and are intentionally unused.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{read_address[31:ADDR_W+2], write_address[31:ADDR_W+2]};

  assign ld_off = read_address[1:0];
  assign ld_idx = read_address[ADDR_W+1:2];
  assign st_off = write_address[1:0];
  assign st_idx = write_address[ADDR_W+1:2];

  assign sb_empty = (count == '0);
  assign sb_full  = (count == (PTR_W+1)'(SB_DEPTH));

  // Load legality: size/alignment check, unknown funct3 codes count as misaligned.
  always_comb begin
    ld_legal = 1'b0;
    case (read_funct3)
      3'b000, 3'b100: ld_legal = 1'b1;
      3'b001, 3'b101: ld_legal = ~ld_off[0];
      3'b010:         ld_legal = (ld_off == 2'b00);
      default:        ld_legal = 1'b0;
    endcase
  end

  // Store legality plus byte-lane mask and lane-shifted data.
  always_comb begin
    st_legal = 1'b0;
    st_mask  = 4'b0000;
    st_wdata = '0;
    case (write_funct3)
      2'b00: begin
        st_legal = 1'b1;
        st_mask  = 4'b0001 << st_off;
        st_wdata = {24'b0, data_write[7:0]} << {st_off, 3'b000};
      end
      2'b01: begin
        st_legal = ~st_off[0];
        st_mask  = 4'b0011 << st_off;
        st_wdata = {16'b0, data_write[15:0]} << {st_off, 3'b000};
      end
      2'b10: begin
        st_legal = (st_off == 2'b00);
        st_mask  = 4'b1111;
        st_wdata = data_write;
      end
      default: begin
        st_legal = 1'b0;
        st_mask  = 4'b0000;
        st_wdata = '0;
      end
    endcase
  end

  // A store colliding with a load is refused only when there is no slot to park it in.
  assign stall  = write_enabled & rd_en & sb_full;
  assign st_acc = write_enabled & ~stall & st_legal;
  assign enq    = st_acc & (rd_en | ~sb_empty);
  assign drain  = ~rd_en & ~sb_empty;
  assign direct = st_acc & ~rd_en & sb_empty;

  // Array write source: the buffer head has priority so stores land in acceptance order.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wmask = 4'b0000;
    mem_wdata = '0;
    if (drain) begin
      mem_we    = 1'b1;
      mem_widx  = sb_idx[head];
      mem_wmask = sb_mask[head];
      mem_wdata = sb_data[head];
    end else if (direct) begin
      mem_we    = 1'b1;
      mem_widx  = st_idx;
      mem_wmask = st_mask;
      mem_wdata = st_wdata;
    end
  end

  // Byte-masked array write; suppressed while reset is held so pending stores are discarded.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Buffer bookkeeping: pointers, occupancy count and valid flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      sb_valid <= '0;
    end else begin
      if (drain) begin
        sb_valid[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (enq) begin
        sb_valid[tail] <= 1'b1;
        tail           <= tail + 1'b1;
      end
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Buffer payload capture; a full buffer overwrites the slot being drained this same edge.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_idx[tail]  <= st_idx;
      sb_mask[tail] <= st_mask;
      sb_data[tail] <= st_wdata;
    end
  end

  // Forwarding merge: array, then buffer oldest-to-youngest, then the same-cycle store.
  always_comb begin
    fwd_word = mem[ld_idx];
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (((PTR_W+1)'(k) < count) && sb_valid[head + PTR_W'(k)] &&
          (sb_idx[head + PTR_W'(k)] == ld_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_mask[head + PTR_W'(k)][b])
            fwd_word[8*b +: 8] = sb_data[head + PTR_W'(k)][8*b +: 8];
        end
      end
    end
    if (st_acc && (st_idx == ld_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (st_mask[b]) fwd_word[8*b +: 8] = st_wdata[8*b +: 8];
      end
    end
  end

  // Lane select and sign/zero extension of the merged word.
  always_comb begin
    sel_word  = fwd_word >> {ld_off, 3'b000};
    ld_result = '0;
    if (ld_legal) begin
      case (read_funct3)
        3'b000:  ld_result = {{24{sel_word[7]}}, sel_word[7:0]};
        3'b100:  ld_result = {24'b0, sel_word[7:0]};
        3'b001:  ld_result = {{16{sel_word[15]}}, sel_word[15:0]};
        3'b101:  ld_result = {16'b0, sel_word[15:0]};
        3'b010:  ld_result = fwd_word;
        default: ld_result = '0;
      endcase
    end
  end

  // Registered load response and misalignment pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      rd_valid   <= 1'b0;
      misaligned <= 2'b00;
    end else begin
      rd_valid   <= rd_en;
      misaligned <= {write_enabled & ~stall & ~st_legal, rd_en & ~ld_legal};
      if (rd_en) data_out <= ld_result;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a byte-level model
module tb_dmem_responder;

  localparam int ADDR_W   = 8;
  localparam int SB_DEPTH = 4;
  localparam int BYTES    = 4 << ADDR_W;

  logic        clk;
  logic        reset;
  logic        rd_en;
  logic [31:0] read_address;
  logic [2:0]  read_funct3;
  logic        write_enabled;
  logic [31:0] write_address;
  logic [31:0] data_write;
  logic [1:0]  write_funct3;
  logic        stall;
  logic [31:0] data_out;
  logic        rd_valid;
  logic [1:0]  misaligned;

  dmem_responder #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_en         (rd_en),
    .read_address  (read_address),
    .read_funct3   (read_funct3),
    .write_enabled (write_enabled),
    .write_address (write_address),
    .data_write    (data_write),
    .write_funct3  (write_funct3),
    .stall         (stall),
    .data_out      (data_out),
    .rd_valid      (rd_valid),
    .misaligned    (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    int          size;
    logic [31:0] data;
  } st_t;

  logic [7:0]  arr_m [BYTES];
  st_t         pend [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        last_stall;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ld_ok(input logic [2:0] f, input logic [31:0] a, output int sz);
    sz = 0;
    case (f)
      3'd0, 3'd4: begin sz = 1; return 1'b1; end
      3'd1, 3'd5: begin sz = 2; return (a % 2) == 0; end
      3'd2:       begin sz = 4; return (a % 4) == 0; end
      default:    return 1'b0;
    endcase
  endfunction

  function automatic bit st_ok(input logic [1:0] f, input logic [31:0] a, output int sz);
    sz = 0;
    case (f)
      2'd0:    begin sz = 1; return 1'b1; end
      2'd1:    begin sz = 2; return (a % 2) == 0; end
      2'd2:    begin sz = 4; return (a % 4) == 0; end
      default: return 1'b0;
    endcase
  endfunction

  // Program-order value of one byte: array, then pending stores in order, then this cycle's store.
  function automatic logic [7:0] model_byte(input int ba, input bit acc, input int wa,
                                            input int wsz, input logic [31:0] wd);
    logic [7:0] v;
    v = arr_m[ba];
    foreach (pend[j]) begin
      if (ba >= pend[j].addr && ba < pend[j].addr + pend[j].size)
        v = pend[j].data[8*(ba - pend[j].addr) +: 8];
    end
    if (acc && ba >= wa && ba < wa + wsz) v = wd[8*(ba - wa) +: 8];
    return v;
  endfunction

  task automatic apply(input st_t s);
    for (int i = 0; i < s.size; i++) arr_m[s.addr + i] = s.data[8*i +: 8];
  endtask

  task automatic cycle(input logic rd, input logic [31:0] ra, input logic [2:0] rf,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [1:0] wf);
    logic        exp_stall;
    bit          lok, sok, acc;
    int          lsz, ssz, la, sa;
    logic [31:0] raw, exp_data;
    logic [1:0]  exp_mis;
    st_t         s, h;
    rd_en = rd; read_address = ra; read_funct3 = rf;
    write_enabled = we; write_address = wa; data_write = wd; write_funct3 = wf;
    #1;
    exp_stall = we && rd && (pend.size() == SB_DEPTH);
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    last_stall = stall;
    lok = ld_ok(rf, ra, lsz);
    sok = st_ok(wf, wa, ssz);
    acc = we && !exp_stall && sok;
    la  = int'(ra % BYTES);
    sa  = int'(wa % BYTES);
    raw = '0;
    if (rd && lok)
      for (int i = 0; i < lsz; i++) raw[8*i +: 8] = model_byte(la + i, acc, sa, ssz, wd);
    exp_data = raw;
    if (!lok)                 exp_data = '0;
    else if (rf == 3'd0)      exp_data = {{24{raw[7]}}, raw[7:0]};
    else if (rf == 3'd1)      exp_data = {{16{raw[15]}}, raw[15:0]};
    exp_mis = {we && !exp_stall && !sok, rd && !lok};
    s.addr = sa; s.size = ssz; s.data = wd;
    if (acc) begin
      if (rd || pend.size() > 0) begin
        if (!rd && pend.size() > 0) begin h = pend.pop_front(); apply(h); end
        pend.push_back(s);
      end else begin
        apply(s);
      end
    end else if (!rd && pend.size() > 0) begin
      h = pend.pop_front();
      apply(h);
    end
    @(posedge clk); #1;
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, rd});
    chk("misaligned", {30'b0, misaligned}, {30'b0, exp_mis});
    if (rd) chk("data_out", data_out, exp_data);
    last_data = exp_data;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 2'd0);
  endtask

  initial begin
    reset = 1'b0; rd_en = 1'b0; read_address = '0; read_funct3 = '0;
    write_enabled = 1'b0; write_address = '0; data_write = '0; write_funct3 = '0;
    #1;
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("reset_misaligned", {30'b0, misaligned}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Fill every word through direct stores so the model knows the whole array.
    for (int w = 0; w < (1 << ADDR_W); w++) cycle(1'b0, 0, 3'd0, 1'b1, w * 4, $urandom, 2'd2);

    // Store then load the same word.
    cycle(1'b0, 0, 3'd0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2);
    cycle(1'b1, 32'h10, 3'd2, 1'b0, 0, 0, 2'd0);
    chk("t2_lw", last_data, 32'hDEADBEEF);
    chk("t2_data_out", data_out, 32'hDEADBEEF);

    // Byte store colliding with a signed byte load at the same address.
    cycle(1'b1, 32'h21, 3'd0, 1'b1, 32'h21, 32'h80, 2'd0);
    chk("t3_lb", data_out, 32'hFFFFFF80);
    idle();
    chk("t3_array_byte", {24'b0, dut.mem[8][15:8]}, 32'h80);

    // Overfill the buffer with collisions; the last one stalls and is re-presented.
    cycle(1'b1, 32'h200, 3'd2, 1'b1, 32'h100, 32'h11111111, 2'd2);
    cycle(1'b1, 32'h204, 3'd2, 1'b1, 32'h104, 32'h22222222, 2'd2);
    cycle(1'b1, 32'h100, 3'd2, 1'b1, 32'h101, 32'h33, 2'd0);
    cycle(1'b1, 32'h104, 3'd1, 1'b1, 32'h108, 32'h44444444, 2'd2);
    cycle(1'b1, 32'h100, 3'd2, 1'b1, 32'h102, 32'h5555, 2'd1);
    chk("t4_stall", {31'b0, last_stall}, 32'h1);
    cycle(1'b0, 0, 3'd0, 1'b1, 32'h102, 32'h5555, 2'd1);
    for (int i = 0; i < SB_DEPTH + 1; i++) idle();
    chk("t4_count_empty", 32'(dut.count), 32'h0);
    cycle(1'b1, 32'h100, 3'd2, 1'b0, 0, 0, 2'd0);
    chk("t4_final_100", data_out, 32'h55553311);
    cycle(1'b1, 32'h104, 3'd2, 1'b0, 0, 0, 2'd0);
    cycle(1'b1, 32'h108, 3'd2, 1'b0, 0, 0, 2'd0);
    chk("t4_final_108", data_out, 32'h44444444);

    // Reset with stores pending: outputs clear, pending stores never reach the array.
    cycle(1'b1, 32'h300, 3'd2, 1'b1, 32'h180, 32'hCAFEF00D, 2'd2);
    cycle(1'b1, 32'h180, 3'd2, 1'b1, 32'h184, 32'hFEEDFACE, 2'd2);
    rd_en = 1'b0; write_enabled = 1'b0;
    reset = 1'b0;
    #1;
    chk("t1_data_out", data_out, 32'h0);
    chk("t1_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("t1_count", 32'(dut.count), 32'h0);
    chk("t1_valid", 32'(dut.sb_valid), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    pend.delete();
    cycle(1'b1, 32'h180, 3'd2, 1'b0, 0, 0, 2'd0);
    cycle(1'b1, 32'h184, 3'd2, 1'b0, 0, 0, 2'd0);

    // Misaligned load and store.
    cycle(1'b1, 32'h3, 3'd1, 1'b0, 0, 0, 2'd0);
    chk("t5_lh_mis", {30'b0, misaligned}, 32'h1);
    chk("t5_lh_data", data_out, 32'h0);
    cycle(1'b0, 0, 3'd0, 1'b1, 32'h6, 32'h12345678, 2'd2);
    chk("t5_sw_mis", {30'b0, misaligned}, 32'h2);
    cycle(1'b1, 32'h4, 3'd2, 1'b0, 0, 0, 2'd0);

    // Buffered halfword, then loads of the untouched and merged halves.
    cycle(1'b1, 32'h80, 3'd2, 1'b1, 32'h40, 32'h1234, 2'd1);
    cycle(1'b1, 32'h42, 3'd5, 1'b0, 0, 0, 2'd0);
    chk("t6_lhu_upper", data_out & 32'hFFFF0000, 32'h0);
    cycle(1'b1, 32'h40, 3'd2, 1'b0, 0, 0, 2'd0);
    chk("t6_lw_merged", data_out & 32'h0000FFFF, 32'h1234);

    // Random traffic over a small window, with wrapping high address bits.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 1), ($urandom & 32'hFFFFFC00) | $urandom_range(0, 63),
            3'($urandom), $urandom_range(0, 1),
            ($urandom & 32'hFFFFFC00) | $urandom_range(0, 63), $urandom, 2'($urandom));
    end
    for (int i = 0; i < SB_DEPTH + 1; i++) idle();

    // Drained array must match the model byte for byte.
    for (int w = 0; w < (1 << ADDR_W); w++)
      chk("array_word", dut.mem[w],
          {arr_m[4*w+3], arr_m[4*w+2], arr_m[4*w+1], arr_m[4*w]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
